response_router: RTL

//  Return path of the shared-resource subsystem. Takes the resource's

---
 rtl/response_router_pkg.sv | 12 +
 rtl/response_router_resp_fifo.sv | 36 +++
 rtl/response_router.sv | 106 ++++++++++
 3 files changed

// File: rtl/response_router_pkg.sv
// response_router_pkg: shared widths, port encoding and entry types for the response return path
package response_router_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int ID_WIDTH = 3;
    localparam int RESP_FIFO_DEPTH = 4;
    localparam logic PORT_1 = 1'b0;
    localparam logic PORT_2 = 1'b1;
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
    } resp_t;
endpackage

// File: rtl/response_router_resp_fifo.sv
// resp_fifo: first-word-fall-through FIFO with wrap-bit pointers, head forced to zero when empty
module resp_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = wr_ptr == rd_ptr;
    assign count = wr_ptr - rd_ptr;
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    // push drops silently when full; pop is ignored when empty
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/response_router.sv
// response_router: steers resource responses to the issuing port, tracks credits and flags protocol errors
module response_router
    import response_router_pkg::*;
#(
    parameter int FIFO_DEPTH = RESP_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_issue_valid,
    input  logic                  in_issue_choice,
    input  logic [ID_WIDTH-1:0]   in_issue_id,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ID_WIDTH-1:0]   in_id,
    input  logic                  in_valid,
    output logic                  out_block_1,
    output logic                  out_block_2,
    output logic [DATA_WIDTH-1:0] out_data_1,
    output logic [ID_WIDTH-1:0]   out_id_1,
    output logic                  out_valid_1,
    input  logic                  in_ready_1,
    output logic [DATA_WIDTH-1:0] out_data_2,
    output logic [ID_WIDTH-1:0]   out_id_2,
    output logic                  out_valid_2,
    input  logic                  in_ready_2,
    output logic                  out_error
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CREDITS = CW'(FIFO_DEPTH);
    logic [2**ID_WIDTH-1:0] src_valid, src_port;
    logic [CW-1:0] reserved_1, reserved_2, reserved_1_next, reserved_2_next;
    logic [CW-1:0] unused_count_1, unused_count_2;
    logic hit, push_1, push_2, pop_1, pop_2, issue_1, issue_2;
    logic full_1, full_2, empty_1, empty_2, err_next;
    resp_t incoming, head_1, head_2;

    function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] r, input logic inc, input logic dec);
        return (inc && !dec && r != FULL_CREDITS) ? r + CW'(1) :
               (dec && !inc && r != '0)           ? r - CW'(1) : r;
    endfunction

    // decode routing, pops, issues, next credits and the error condition
    always_comb begin
        hit             = in_valid && src_valid[in_id];
        push_1          = hit && src_port[in_id] == PORT_1;
        push_2          = hit && src_port[in_id] == PORT_2;
        pop_1           = !empty_1 && in_ready_1;
        pop_2           = !empty_2 && in_ready_2;
        issue_1         = in_issue_valid && in_issue_choice == PORT_1;
        issue_2         = in_issue_valid && in_issue_choice == PORT_2;
        reserved_1_next = credit_next(reserved_1, issue_1, pop_1);
        reserved_2_next = credit_next(reserved_2, issue_2, pop_2);
        incoming        = '{data: in_data, id: in_id};
        err_next        = (in_valid && !src_valid[in_id]) ||
                          (issue_1 && out_block_1) || (issue_2 && out_block_2) ||
                          (in_issue_valid && src_valid[in_issue_id] && !(hit && in_id == in_issue_id)) ||
                          (push_1 && full_1) || (push_2 && full_2);
    end

    // source table: a response frees its entry, then a same-cycle issue rewrites it
    always_ff @(posedge clk) begin
        if (reset) begin
            src_valid <= '0;
            src_port  <= '0;
        end else begin
            if (hit) src_valid[in_id] <= 1'b0;
            if (in_issue_valid) begin
                src_valid[in_issue_id] <= 1'b1;
                src_port[in_issue_id]  <= in_issue_choice;
            end
        end
    end

    // credits, block flags from next-state credits, and the registered error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            reserved_1  <= '0;
            reserved_2  <= '0;
            out_block_1 <= 1'b0;
            out_block_2 <= 1'b0;
            out_error   <= 1'b0;
        end else begin
            reserved_1  <= reserved_1_next;
            reserved_2  <= reserved_2_next;
            out_block_1 <= reserved_1_next == FULL_CREDITS;
            out_block_2 <= reserved_2_next == FULL_CREDITS;
            out_error   <= err_next;
        end
    end

    resp_fifo #(.WIDTH($bits(resp_t)), .DEPTH(FIFO_DEPTH)) u_fifo_1 (
        .clk(clk), .reset(reset), .push(push_1), .din(incoming), .pop(pop_1),
        .dout(head_1), .full(full_1), .empty(empty_1), .count(unused_count_1)
    );

    resp_fifo #(.WIDTH($bits(resp_t)), .DEPTH(FIFO_DEPTH)) u_fifo_2 (
        .clk(clk), .reset(reset), .push(push_2), .din(incoming), .pop(pop_2),
        .dout(head_2), .full(full_2), .empty(empty_2), .count(unused_count_2)
    );

    assign out_valid_1 = !empty_1;
    assign out_data_1  = head_1.data;
    assign out_id_1    = head_1.id;
    assign out_valid_2 = !empty_2;
    assign out_data_2  = head_2.data;
    assign out_id_2    = head_2.id;
endmodule
